// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: FSM state encoding,
// the redirect-source select used by the priority mux, and the default trap vector.
package pc_redirect_ctrl_pkg;

    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_HALTED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } redir_state_e;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_TRAP   = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_RESUME = 2'd3
    } redir_src_e;

endpackage : pc_redirect_ctrl_pkg

// File: rtl/pc_redirect_ctrl_flush_timer.sv
// pc_flush_timer: load/decrement down-counter that times the wrong-path squash
// window. Load has priority over decrement; the counter saturates at zero.
module pc_flush_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk_pi,
    input  logic             reset_pi,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Down-counter register: reload on a new redirect, otherwise count toward zero.
    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule : pc_flush_timer

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates trap / branch / HALT / stall / debug-resume PC changes,
// drives the PC register's halt and redirect inputs combinationally, squashes
// wrong-path slots after each redirect and counts accepted redirects.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
    parameter int          REDIR_CNT_W  = 16
) (
    input  logic                   clk_pi,
    input  logic                   reset_pi,
    input  logic                   branchTaken_pi,
    input  logic [31:0]            branchTarget_pi,
    input  logic                   trap_pi,
    input  logic                   haltInstr_pi,
    input  logic                   imemStall_pi,
    input  logic                   resume_pi,
    input  logic [31:0]            resumePC_pi,
    output logic                   halt_po,
    output logic                   isTakenBranch_po,
    output logic [31:0]            targetPC_po,
    output logic                   flush_po,
    output logic                   halted_po,
    output logic [REDIR_CNT_W-1:0] redirCount_po
);

    localparam int FLUSH_CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    redir_state_e           state_r;
    redir_state_e           state_next_s;
    redir_src_e             redir_src_s;
    logic                   redirect_s;
    logic                   flush_zero_s;
    logic [REDIR_CNT_W-1:0] redir_cnt_r;

    // State register; reset (and the illegal-state recovery in next-state logic) returns to RUN.
    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Priority mux: choose which request, if any, redirects the PC this cycle.
    always_comb begin
        redir_src_s = SRC_NONE;
        case (state_r)
            ST_RUN: begin
                if (trap_pi) begin
                    redir_src_s = SRC_TRAP;
                end else if (branchTaken_pi) begin
                    redir_src_s = SRC_BRANCH;
                end else begin
                    redir_src_s = SRC_NONE;
                end
            end
            ST_FLUSH: begin
                // Branches seen during the squash window are wrong-path; traps are not.
                if (trap_pi) begin
                    redir_src_s = SRC_TRAP;
                end else begin
                    redir_src_s = SRC_NONE;
                end
            end
            ST_HALTED: begin
                if (resume_pi) begin
                    redir_src_s = SRC_RESUME;
                end else begin
                    redir_src_s = SRC_NONE;
                end
            end
            default: redir_src_s = SRC_NONE;
        endcase
    end

    assign redirect_s = (redir_src_s != SRC_NONE) && !reset_pi;

    // Next-state logic.
    always_comb begin
        state_next_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (redirect_s) begin
                    state_next_s = ST_FLUSH;
                end else if (haltInstr_pi) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (redirect_s) begin
                    state_next_s = ST_FLUSH;
                end else if (flush_zero_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            ST_HALTED: begin
                if (redirect_s) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Output logic: combinational so the PC register consumes it at the same edge.
    always_comb begin
        halt_po          = 1'b0;
        isTakenBranch_po = 1'b0;
        targetPC_po      = 32'h0000_0000;
        flush_po         = 1'b0;
        halted_po        = 1'b0;
        if (reset_pi) begin
            halt_po          = 1'b0;
            isTakenBranch_po = 1'b0;
        end else begin
            isTakenBranch_po = redirect_s;
            case (redir_src_s)
                SRC_TRAP:   targetPC_po = TRAP_VECTOR;
                SRC_BRANCH: targetPC_po = branchTarget_pi;
                SRC_RESUME: targetPC_po = resumePC_pi;
                default:    targetPC_po = 32'h0000_0000;
            endcase
            case (state_r)
                ST_RUN: begin
                    // A redirect always beats a stall or HALT in the same cycle.
                    halt_po = !redirect_s && (haltInstr_pi || imemStall_pi);
                end
                ST_FLUSH: begin
                    flush_po = 1'b1;
                    halt_po  = !redirect_s && imemStall_pi;
                end
                ST_HALTED: begin
                    halt_po   = 1'b1;
                    halted_po = 1'b1;
                end
                default: begin
                    halt_po = 1'b0;
                end
            endcase
        end
    end

    // Accepted-redirect counter, wraps naturally at its width.
    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            redir_cnt_r <= '0;
        end else if (isTakenBranch_po) begin
            redir_cnt_r <= redir_cnt_r + REDIR_CNT_W'(1);
        end else begin
            redir_cnt_r <= redir_cnt_r;
        end
    end

    assign redirCount_po = redir_cnt_r;

    pc_flush_timer #(
        .CNT_W (FLUSH_CNT_W)
    ) u_flush_timer (
        .clk_pi   (clk_pi),
        .reset_pi (reset_pi),
        .load     (redirect_s),
        .load_val (FLUSH_LOAD),
        .dec      (state_r == ST_FLUSH),
        .zero     (flush_zero_s)
    );

endmodule : pc_redirect_ctrl

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios followed by
// randomized stimulus, all compared against a cycle-level behavioural model.
module tb_pc_redirect_ctrl;

    localparam int          FLUSH_N = 2;
    localparam logic [31:0] TRAP_PC = 32'h0000_0100;

    logic        clk_pi = 1'b0;
    logic        reset_pi;
    logic        branchTaken_pi;
    logic [31:0] branchTarget_pi;
    logic        trap_pi;
    logic        haltInstr_pi;
    logic        imemStall_pi;
    logic        resume_pi;
    logic [31:0] resumePC_pi;
    logic        halt_po;
    logic        isTakenBranch_po;
    logic [31:0] targetPC_po;
    logic        flush_po;
    logic        halted_po;
    logic [15:0] redirCount_po;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: whether halted, how many squash cycles remain, redirect tally.
    bit          m_halted;
    int          m_flush_left;
    logic [15:0] m_count;
    logic [31:0] m_pc;

    pc_redirect_ctrl #(
        .FLUSH_CYCLES (FLUSH_N),
        .TRAP_VECTOR  (TRAP_PC),
        .REDIR_CNT_W  (16)
    ) dut (
        .clk_pi           (clk_pi),
        .reset_pi         (reset_pi),
        .branchTaken_pi   (branchTaken_pi),
        .branchTarget_pi  (branchTarget_pi),
        .trap_pi          (trap_pi),
        .haltInstr_pi     (haltInstr_pi),
        .imemStall_pi     (imemStall_pi),
        .resume_pi        (resume_pi),
        .resumePC_pi      (resumePC_pi),
        .halt_po          (halt_po),
        .isTakenBranch_po (isTakenBranch_po),
        .targetPC_po      (targetPC_po),
        .flush_po         (flush_po),
        .halted_po        (halted_po),
        .redirCount_po    (redirCount_po)
    );

    // Free-running clock, period 10.
    always #5 clk_pi = ~clk_pi;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rst, input bit br, input logic [31:0] tgt, input bit trp,
                        input bit hlt, input bit stl, input bit res, input logic [31:0] rpc);
        bit          e_redir;
        bit          e_halt;
        bit          e_flush;
        bit          e_halted;
        logic [31:0] e_tgt;
        @(negedge clk_pi);
        reset_pi = rst; branchTaken_pi = br; branchTarget_pi = tgt; trap_pi = trp;
        haltInstr_pi = hlt; imemStall_pi = stl; resume_pi = res; resumePC_pi = rpc;
        #1;
        e_redir = 1'b0; e_halt = 1'b0; e_flush = 1'b0; e_halted = 1'b0; e_tgt = 32'h0;
        if (rst) begin
            // everything forced low
        end else if (m_halted) begin
            e_halt = 1'b1; e_halted = 1'b1;
            if (res) begin e_redir = 1'b1; e_tgt = rpc; end
        end else if (m_flush_left > 0) begin
            e_flush = 1'b1;
            if (trp) begin e_redir = 1'b1; e_tgt = TRAP_PC; end
            e_halt = stl && !e_redir;
        end else begin
            if (trp) begin e_redir = 1'b1; e_tgt = TRAP_PC; end
            else if (br) begin e_redir = 1'b1; e_tgt = tgt; end
            e_halt = !e_redir && (hlt || stl);
        end
        check_eq("halt",      {31'd0, halt_po},          {31'd0, e_halt});
        check_eq("redirect",  {31'd0, isTakenBranch_po}, {31'd0, e_redir});
        check_eq("target",    targetPC_po,               e_tgt);
        check_eq("flush",     {31'd0, flush_po},         {31'd0, e_flush});
        check_eq("halted",    {31'd0, halted_po},        {31'd0, e_halted});
        check_eq("redir_cnt", {16'd0, redirCount_po},    {16'd0, m_count});
        // Advance the model to the state after this edge; m_pc tracks a simple PC (+4 unless held).
        if (rst) begin
            m_halted = 1'b0; m_flush_left = 0; m_count = 16'd0; m_pc = 32'h0;
        end else begin
            if (e_redir) begin
                m_count = m_count + 16'd1;
                m_pc = e_tgt;
            end else if (!e_halt) begin
                m_pc = m_pc + 32'd4;
            end else begin
                m_pc = m_pc;
            end
            if (m_halted) begin
                if (res) begin m_halted = 1'b0; m_flush_left = FLUSH_N; end
            end else if (m_flush_left > 0) begin
                if (trp) m_flush_left = FLUSH_N;
                else     m_flush_left = m_flush_left - 1;
            end else begin
                if (e_redir)  m_flush_left = FLUSH_N;
                else if (hlt) m_halted = 1'b1;
            end
        end
        @(posedge clk_pi);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] pc_before;
        m_halted = 1'b0; m_flush_left = 0; m_count = 16'd0; m_pc = 32'h0;
        reset_pi = 1'b1; branchTaken_pi = 1'b0; branchTarget_pi = 32'h0; trap_pi = 1'b0;
        haltInstr_pi = 1'b0; imemStall_pi = 1'b0; resume_pi = 1'b0; resumePC_pi = 32'h0;

        // Reset, then idle.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);

        // Taken branch to 0x40, two squash cycles, back to RUN.
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("branch_pc", m_pc, 32'h40);
        idle(3);
        check_eq("cnt_after_branch", {16'd0, redirCount_po}, 32'd1);

        // Branch to 0x80 then a wrong-path HALT.
        step(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(3);

        // Trap beats branch; trap again mid-flush reloads the window.
        step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);

        // HALT held through branch pulses, then resume at 0x200.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++)
            step(1'b0, k[0], 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        idle(3);

        // Stall holds the PC; stall coinciding with a branch is overridden.
        pc_before = m_pc;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("stall_pc_hold", m_pc, pc_before);
        step(1'b0, 1'b1, 32'h600, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        // Reset in the middle of the flush window.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);

        // Randomized stimulus.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(99) < 2),
                 ($urandom_range(99) < 20), $urandom,
                 ($urandom_range(99) < 6),
                 ($urandom_range(99) < 10),
                 ($urandom_range(99) < 25),
                 ($urandom_range(99) < 30), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_redirect_ctrl
